// File: rtl/operand_select_buffer_if.sv
// Operand request / result bundle between the issue logic, the operand
// select buffer and the execute stage.
interface operand_select_buffer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned SELW  = 3
);
    // Request side
    logic                   in_valid;
    logic                   in_ready;
    logic [SELW-1:0]        reg_select;
    logic                   reg_r_select;
    logic                   imm_select;
    logic [WIDTH-1:0]       imm;
    logic [WIDTH-1:0]       reg_r;
    logic [NREGS*WIDTH-1:0] regs;

    // Execute side
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [1:0]             out_src;

    // Occupancy
    logic [1:0]             count;

    // Requester / consumer view
    modport master (
        output in_valid, reg_select, reg_r_select, imm_select, imm, reg_r, regs, out_ready,
        input  in_ready, out_valid, out_data, out_src, count
    );

    // Buffer view
    modport slave (
        input  in_valid, reg_select, reg_r_select, imm_select, imm, reg_r, regs, out_ready,
        output in_ready, out_valid, out_data, out_src, count
    );
endinterface

// File: rtl/operand_select_buffer.sv
// Registered operand multiplexer: picks reg_r, imm or a bank register, and
// captures the value with a source tag into a 2-entry FIFO skid buffer that
// feeds the execute stage over a valid/ready handshake.
module operand_select_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned SELW  = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    operand_select_buffer_if.slave  bus
);

    localparam logic [1:0] SrcReg = 2'd0;
    localparam logic [1:0] SrcR   = 2'd1;
    localparam logic [1:0] SrcImm = 2'd2;
    localparam logic [1:0] SrcBad = 2'd3;

    // Encoding equals the occupancy so count is taken straight from the state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]       src;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    logic [WIDTH-1:0] sel_data;
    logic [1:0]       sel_src;
    logic             push;
    logic             pop;
    logic             in_ready;
    logic             out_valid;
    entry_t           head;

    // Source selection by priority: reg_r, then imm, then in-range bank register.
    always_comb begin
        sel_data = '0;
        sel_src  = SrcBad;
        if (bus.reg_r_select) begin
            sel_data = bus.reg_r;
            sel_src  = SrcR;
        end else if (bus.imm_select) begin
            sel_data = bus.imm;
            sel_src  = SrcImm;
        end else begin
            // Walk only the populated indices so an out-of-range select never
            // reads past the bank; it falls through as zero data / bad tag.
            for (int k = 0; k < int'(NREGS); k++) begin
                if (bus.reg_select == SELW'(k)) begin
                    sel_data = bus.regs[k*WIDTH +: WIDTH];
                    sel_src  = SrcReg;
                end
            end
        end
    end

    // Handshake qualifiers; ready/valid depend only on registered state.
    always_comb begin
        in_ready  = (state_q != StFull);
        out_valid = (state_q != StEmpty);
        push      = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
    end

    // Occupancy next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                end
            end
            StOne: begin
                // Simultaneous push and pop keeps one entry: the new one.
                if (push && !pop) begin
                    state_d = StFull;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot storage and pointers; operands are sampled only on the push edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= '{src: sel_src, data: sel_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Head presentation; zeroed while the buffer is empty.
    always_comb begin
        head = out_valid ? slot_q[rd_ptr_q] : '0;
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_data  = head.data;
        bus.out_src   = head.src;
        bus.count     = state_q;
    end

endmodule

// File: doc/operand_select_buffer.md
# operand_select_buffer

Parametrised, registered successor to the processor's combinational operand multiplexer. Selects one operand from a bank of NREGS general-purpose register values, the R register, or an immediate. It captures the selected value together with a source tag into a 2-entry FIFO skid buffer, and presents it to the execute stage over a valid/ready handshake. Operands are sampled at acceptance, so later register-file writes cannot corrupt a buffered operand.

## Interface
- WIDTH, 16, operand width in bits.
- NREGS, 8, number of register inputs (2..16).
- SELW, 3, reg_select width; must satisfy 2**SELW >= NREGS.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  selection request present.
- in_ready  out  1  buffer can accept; equals (count < 2), combinational from count only.
- reg_select  in  SELW  register index.
- reg_r_select  in  1  choose reg_r.
- imm_select  in  1  choose imm.
- imm  in  WIDTH  immediate operand.
- reg_r  in  WIDTH  R register value.
- regs  in  NREGS*WIDTH  flattened bank; register k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry.
- out_data  out  WIDTH  head operand.
- out_src  out  2  head source tag: 0 = register bank, 1 = reg_r, 2 = imm, 3 = invalid index.
- count  out  2  occupancy, 0..2.

## Operation
- Source priority, evaluated at acceptance:
  1. reg_r_select=1: data = reg_r, tag 1.
  2. Otherwise imm_select=1: data = imm, tag 2.
  3. Otherwise reg_select < NREGS: data = regs[reg_select], tag 0.
  4. Otherwise: data = 0, tag 3.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- FIFO order is strict. Entry storage is two slots, each holding WIDTH+2 bits, with head/tail pointers or an equivalent shift structure.
- States by count:
  - EMPTY (0): push goes to ONE.
  - ONE (1):
    - push only: go to FULL.
    - pop only: go to EMPTY.
    - push and pop together: stay in ONE; the new entry becomes head.
  - FULL (2): pop goes to ONE. Push is impossible because in_ready=0.
- out_valid = (count != 0).
- When count=0, out_data and out_src are forced to 0.
- Inputs are sampled only on the push edge. Changes to regs, reg_r, or imm afterwards never alter stored entries.
- in_valid with in_ready=0 is ignored. Nothing is latched, and the requester must hold the request.
- reset: count=0, both slots cleared to 0, pointers to slot 0. Any buffered entries are discarded, including ones mid-handshake.
- Reset overrides a simultaneous push/pop on the same edge.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, count=0, in_ready=1 (from the first cycle after reset).
- Latency: an operand pushed at edge N is visible on out_data/out_valid after edge N (same cycle as count update), i.e. one cycle from request to output.
- Throughput: one operand per cycle sustained when out_ready is held high (count stays at or below 1).
- Backpressure: with out_ready=0, two pushes fill the buffer. in_ready drops in the cycle after the second push edge. The first pop reasserts in_ready one cycle later.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

## Test plan
- Reset then basic select: regs[2]=3, reg_select=2, one push -> next cycle out_valid=1, out_data=3, out_src=0, count=1. Pop -> count=0, out_data=0.
- Priority: push regs[2]=3, reg_r=30, imm=42 with reg_r_select=1, imm_select=1, then with only imm_select=1, with out_ready=1 throughout -> out_data sequence 30 (src 1), 42 (src 2), one per cycle.
- Capture isolation: push reg_select=3 with regs[3]=0 and out_ready=0, then set regs[3]=8 -> out_data stays 0 until popped. A new push now yields 8.
- Backpressure/full: out_ready=0, push reg_select=6 (value 15) then reg_select=2 (value 3), third request held -> count=2, in_ready=0, third not accepted. Raise out_ready -> 15, 3, then the held request, in order.
- Simultaneous push+pop at count=1 -> count stays 1, head is the new entry, no loss or duplication.
- Invalid index with NREGS=6, SELW=3: reg_select=7 -> out_data=0, out_src=3. Assert reset while count=2 -> next cycle count=0, out_valid=0, in_ready=1.
